// File: rtl/pacman_bus_pkg.sv
// Shared types and address map for the Pac-Man CPU bus responder.
// Holds the FSM and region enums plus the decode helper used by the top.
package pacman_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MEM_WAIT,
        ST_DONE
    } state_t;

    typedef enum logic [2:0] {
        RGN_ROM,
        RGN_RAM,
        RGN_REG,
        RGN_IO,
        RGN_UNMAPPED
    } region_t;

    localparam logic [15:0] ROM_END     = 16'h3FFF;
    localparam logic [15:0] RAM_BASE    = 16'h4000;
    localparam logic [15:0] RAM_END     = 16'h4FFF;
    localparam logic [15:0] REG_BASE    = 16'h5000;
    localparam logic [15:0] REG_END     = 16'h50FF;
    localparam logic [15:0] IN0_ADDR    = 16'h5000;
    localparam logic [15:0] IN1_ADDR    = 16'h5040;
    localparam logic [15:0] IRQ_EN_ADDR = 16'h5000;
    localparam logic [7:0]  VEC_PORT    = 8'h00;
    localparam logic [7:0]  OPEN_BUS    = 8'hFF;

    function automatic region_t decode_region(input logic iorq, input logic [15:0] addr);
        if (iorq)
            return RGN_IO;
        else if (addr <= ROM_END)
            return RGN_ROM;
        else if (addr >= RAM_BASE && addr <= RAM_END)
            return RGN_RAM;
        else if (addr >= REG_BASE && addr <= REG_END)
            return RGN_REG;
        else
            return RGN_UNMAPPED;
    endfunction

endpackage

// File: rtl/pacman_bus_if.sv
// CPU-side and memory-side bus signals of the responder.
// The slave modport is the responder's view; master is the CPU/memory side.
interface pacman_bus_if;
    logic        m1_n;
    logic        iorq;
    logic        no_read;
    logic        write;
    logic        rfsh_n;
    logic [15:0] A;
    logic [7:0]  dout;
    logic [6:0]  ts;
    logic [7:0]  di;
    logic        wait_n;
    logic        int_n;
    logic        mem_req;
    logic        mem_we;
    logic [14:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;

    modport slave (
        input  m1_n, iorq, no_read, write, rfsh_n, A, dout, ts, mem_rdata, mem_ack,
        output di, wait_n, int_n, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output m1_n, iorq, no_read, write, rfsh_n, A, dout, ts, mem_rdata, mem_ack,
        input  di, wait_n, int_n, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/pacman_irq_ctrl.sv
// VBLANK interrupt controller: enable bit, pending flag, IM2 vector latch.
// A vblank rise coinciding with an acknowledge wins, so the new interrupt is kept.
module pacman_irq_ctrl (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       vblank,
    input  logic       en_wr,
    input  logic       en_val,
    input  logic       vec_wr,
    input  logic [7:0] vec_val,
    input  logic       ack,
    output logic [7:0] vector,
    output logic       int_n
);
    logic       vblank_reg;
    logic       irq_en_reg;
    logic       pending_reg;
    logic       pending_next;
    logic [7:0] vector_reg;
    logic       vblank_rise;

    assign vblank_rise = vblank && !vblank_reg;

    always_comb begin
        pending_next = pending_reg;
        if (ack)
            pending_next = 1'b0;
        if (vblank_rise && irq_en_reg)
            pending_next = 1'b1;
        // disabling interrupts also drops whatever is already pending
        if (en_wr && !en_val)
            pending_next = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vblank_reg  <= 1'b0;
            irq_en_reg  <= 1'b0;
            pending_reg <= 1'b0;
            vector_reg  <= 8'h00;
        end else begin
            vblank_reg  <= vblank;
            pending_reg <= pending_next;
            if (en_wr)
                irq_en_reg <= en_val;
            if (vec_wr)
                vector_reg <= vec_val;
        end
    end

    assign vector = vector_reg;
    assign int_n  = !pending_reg;
endmodule

// File: rtl/pacman_bus_responder.sv
// Z80 bus responder: decodes each T2 access, runs ROM/RAM through a wait-state
// memory handshake and serves registers, IO and interrupt acknowledge zero-wait.
module pacman_bus_responder
    import pacman_bus_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    pacman_bus_if.slave bus,
    input  logic        vblank,
    input  logic [7:0]  in0,
    input  logic [7:0]  in1
);
    state_t      state_reg;
    state_t      state_next;
    region_t     region;
    logic        start;
    logic        is_wr;
    logic        is_rd;
    logic        is_ack;
    logic        mem_start;
    logic        zw_start;
    logic        irq_en_wr;
    logic        vec_wr;
    logic [7:0]  zw_data;
    logic [7:0]  vector;
    logic [7:0]  di_reg;
    logic [7:0]  mem_wdata_reg;
    logic [14:0] mem_addr_reg;
    logic        mem_req_reg;
    logic        mem_we_reg;
    logic        unused_ts;

    assign unused_ts = ^{bus.ts[6:2], bus.ts[0]};
    assign region    = decode_region(bus.iorq, bus.A);
    assign start     = bus.ts[1] && bus.rfsh_n && (state_reg == ST_IDLE);
    assign is_wr     = bus.write;
    assign is_rd     = !bus.write && !bus.no_read;
    assign is_ack    = start && !bus.m1_n && bus.iorq;
    // ROM writes are deliberately absent here: they finish zero-wait and never reach memory
    assign mem_start = start && ((region == RGN_ROM && is_rd) ||
                                 (region == RGN_RAM && (is_rd || is_wr)));
    assign zw_start  = start && !is_ack && !mem_start && (is_rd || is_wr);
    assign irq_en_wr = zw_start && is_wr && region == RGN_REG && bus.A == IRQ_EN_ADDR;
    assign vec_wr    = zw_start && is_wr && region == RGN_IO && bus.A[7:0] == VEC_PORT;

    always_comb begin
        zw_data = OPEN_BUS;
        if (region == RGN_REG) begin
            if (bus.A == IN0_ADDR)
                zw_data = in0;
            else if (bus.A == IN1_ADDR)
                zw_data = in1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (mem_start)
                    state_next = ST_MEM_WAIT;
                else if (is_ack || zw_start)
                    state_next = ST_DONE;
            end
            ST_MEM_WAIT: begin
                if (bus.mem_ack)
                    state_next = ST_DONE;
            end
            ST_DONE: begin
                if (!bus.ts[1])
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            di_reg        <= OPEN_BUS;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
        end else begin
            if (mem_start) begin
                mem_req_reg   <= 1'b1;
                mem_we_reg    <= is_wr;
                mem_addr_reg  <= bus.A[14:0];
                mem_wdata_reg <= bus.dout;
            end else if (state_reg == ST_MEM_WAIT && bus.mem_ack) begin
                mem_req_reg <= 1'b0;
                if (!mem_we_reg)
                    di_reg <= bus.mem_rdata;
            end
            if (is_ack)
                di_reg <= vector;
            else if (zw_start && is_rd)
                di_reg <= zw_data;
        end
    end

    pacman_irq_ctrl u_irq (
        .clk     (clk),
        .reset_n (reset_n),
        .vblank  (vblank),
        .en_wr   (irq_en_wr),
        .en_val  (bus.dout[0]),
        .vec_wr  (vec_wr),
        .vec_val (bus.dout),
        .ack     (is_ack),
        .vector  (vector),
        .int_n   (bus.int_n)
    );

    // gated by reset_n so a held start cycle cannot stall the CPU during reset
    assign bus.wait_n    = !(reset_n && (mem_start || state_reg == ST_MEM_WAIT));
    assign bus.di        = di_reg;
    assign bus.mem_req   = mem_req_reg;
    assign bus.mem_we    = mem_we_reg;
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_wdata = mem_wdata_reg;
endmodule

// File: tb/tb_pacman_bus_responder.sv
// Bench for pacman_bus_responder: a transaction-level CPU/memory model drives
// directed and random accesses while one process compares outputs every cycle.
module tb_pacman_bus_responder;
    localparam logic [6:0] T1 = 7'b0000001;
    localparam logic [6:0] T2 = 7'b0000010;
    localparam logic [6:0] T3 = 7'b0000100;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       vblank = 1'b0;
    logic [7:0] in0 = 8'h00;
    logic [7:0] in1 = 8'h00;

    pacman_bus_if bus ();

    pacman_bus_responder dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .vblank  (vblank),
        .in0     (in0),
        .in1     (in1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // expected outputs for the current cycle
    logic [7:0]  exp_di = 8'hFF;
    logic        exp_wait_n = 1'b1;
    logic        exp_int_n = 1'b1;
    logic        exp_mem_req = 1'b0;
    logic        exp_mem_we = 1'b0;
    logic [14:0] exp_mem_addr = '0;
    logic [7:0]  exp_mem_wdata = '0;
    bit          chk_en = 1'b0;
    bit          vb_rand = 1'b0;

    // behavioural state
    logic [7:0] mem_model [32768];
    bit         m_irq_en = 0;
    bit         m_pending = 0;
    bit         m_vblank_prev = 0;
    logic [7:0] m_vector = 8'h00;

    // events happening in the current cycle, consumed at the next edge
    bit         ev_en_wr = 0;
    bit         ev_en_val = 0;
    bit         ev_vec_wr = 0;
    logic [7:0] ev_vec_val = 8'h00;
    bit         ev_ack = 0;

    // observation counters and snapshots, written only by the compare process
    int          wait_low_cnt = 0;
    int          req_cnt = 0;
    logic [14:0] snap_addr = '0;
    logic [7:0]  snap_wdata = '0;
    logic        snap_we = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!bus.wait_n) wait_low_cnt++;
        if (bus.mem_req) req_cnt++;
        if (bus.mem_req && bus.mem_ack) begin
            snap_addr  = bus.mem_addr;
            snap_wdata = bus.mem_wdata;
            snap_we    = bus.mem_we;
        end
        if (chk_en) begin
            chk("di", 32'(bus.di), 32'(exp_di));
            chk("wait_n", 32'(bus.wait_n), 32'(exp_wait_n));
            chk("int_n", 32'(bus.int_n), 32'(exp_int_n));
            chk("mem_req", 32'(bus.mem_req), 32'(exp_mem_req));
            if (exp_mem_req) begin
                chk("mem_addr", 32'(bus.mem_addr), 32'(exp_mem_addr));
                chk("mem_we", 32'(bus.mem_we), 32'(exp_mem_we));
                chk("mem_wdata", 32'(bus.mem_wdata), 32'(exp_mem_wdata));
            end
        end
    end

    // advance one clock edge and apply the interrupt rules at that edge
    task automatic tick();
        bit rise;
        @(posedge clk);
        rise = vblank && !m_vblank_prev;
        m_pending = (m_pending && !ev_ack) || (rise && m_irq_en);
        if (ev_en_wr) begin
            m_irq_en = ev_en_val;
            if (!ev_en_val) m_pending = 0;
        end
        if (ev_vec_wr) m_vector = ev_vec_val;
        m_vblank_prev = vblank;
        ev_en_wr = 0; ev_en_val = 0; ev_vec_wr = 0; ev_ack = 0;
        #1;
        if (vb_rand && $urandom_range(0, 5) == 0) vblank = !vblank;
        exp_int_n = !m_pending;
    endtask

    task automatic stray();
        bus.mem_ack   = ($urandom_range(0, 3) == 0);
        bus.mem_rdata = 8'($urandom);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            bus.ts = T1; bus.iorq = 1'b0; bus.m1_n = 1'b1;
            bus.write = 1'b0; bus.no_read = 1'b1;
            stray();
            tick();
        end
    endtask

    // one complete bus access: T2 start, optional memory wait, then T3
    task automatic access(input logic [15:0] a, input logic wr, input logic nrd,
                          input logic io, input logic m1, input logic [7:0] d, input int lat);
        bit rd, ack, mem;
        logic [7:0] new_di;
        rd  = !wr && !nrd;
        ack = io && !m1;
        mem = !io && ((rd && a <= 16'h4FFF) || (wr && a >= 16'h4000 && a <= 16'h4FFF));
        new_di = exp_di;
        bus.ts = T2; bus.rfsh_n = 1'b1; bus.A = a; bus.write = wr; bus.no_read = nrd;
        bus.iorq = io; bus.m1_n = m1; bus.dout = d;
        stray();
        if (mem) begin
            exp_wait_n = 1'b0;
            tick();
            for (int k = 1; k <= lat; k++) begin
                exp_mem_req = 1'b1; exp_mem_we = wr; exp_mem_addr = a[14:0];
                exp_mem_wdata = d; exp_wait_n = 1'b0;
                bus.mem_ack   = (k == lat);
                bus.mem_rdata = (k == lat) ? mem_model[a[14:0]] : 8'($urandom);
                tick();
            end
            if (rd) new_di = mem_model[a[14:0]];
            else    mem_model[a[14:0]] = d;
            exp_mem_req = 1'b0;
        end else begin
            exp_wait_n = 1'b1;
            if (ack) begin
                new_di = m_vector;
                ev_ack = 1;
            end else if (rd) begin
                if (io || a == 16'h5000 && 1'b0) new_di = 8'hFF;
                else if (a == 16'h5000) new_di = in0;
                else if (a == 16'h5040) new_di = in1;
                else new_di = 8'hFF;
            end else if (wr) begin
                if (!io && a == 16'h5000) begin ev_en_wr = 1; ev_en_val = d[0]; end
                if (io && a[7:0] == 8'h00) begin ev_vec_wr = 1; ev_vec_val = d; end
            end
            tick();
        end
        exp_di = new_di;
        exp_wait_n = 1'b1;
        bus.ts = T3;
        stray();
        tick();
    endtask

    initial begin
        int base_w;
        int base_r;
        for (int i = 0; i < 32768; i++) mem_model[i] = 8'($urandom);
        bus.ts = T1; bus.rfsh_n = 1'b1; bus.m1_n = 1'b1; bus.iorq = 1'b0;
        bus.write = 1'b0; bus.no_read = 1'b1; bus.A = '0; bus.dout = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_di", 32'(bus.di), 32'hFF);
        chk("rst_wait_n", 32'(bus.wait_n), 32'h1);
        chk("rst_int_n", 32'(bus.int_n), 32'h1);
        chk("rst_mem_req", 32'(bus.mem_req), 32'h0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'h0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
        chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'h0);
        reset_n = 1'b1;
        chk_en = 1'b1;
        idle(2);

        // ROM read with ack in the third mem_req cycle
        mem_model[15'h0123] = 8'h3E;
        base_w = wait_low_cnt;
        access(16'h0123, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 3);
        chk("rom_rd_wait_cycles", 32'(wait_low_cnt - base_w), 32'd4);
        chk("rom_rd_di", 32'(bus.di), 32'h3E);
        chk("rom_rd_we", 32'(snap_we), 32'h0);

        // RAM write, then ROM write that must stay off the memory bus
        access(16'h4C00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5A, 2);
        chk("ram_wr_addr", 32'(snap_addr), 32'h4C00);
        chk("ram_wr_data", 32'(snap_wdata), 32'h5A);
        chk("ram_wr_we", 32'(snap_we), 32'h1);
        base_w = wait_low_cnt; base_r = req_cnt;
        access(16'h0010, 1'b1, 1'b0, 1'b0, 1'b1, 8'h77, 1);
        chk("rom_wr_no_req", 32'(req_cnt - base_r), 32'd0);
        chk("rom_wr_no_wait", 32'(wait_low_cnt - base_w), 32'd0);

        // register and unmapped reads
        in1 = 8'h9F;
        base_w = wait_low_cnt;
        access(16'h5040, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1);
        chk("in1_rd_di", 32'(bus.di), 32'h9F);
        chk("in1_rd_no_wait", 32'(wait_low_cnt - base_w), 32'd0);
        access(16'h6000, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1);
        chk("unmapped_rd_di", 32'(bus.di), 32'hFF);

        // vector latch, enable, vblank, acknowledge
        access(16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 8'hCF, 1);
        access(16'h5000, 1'b1, 1'b1, 1'b0, 1'b1, 8'h01, 1);
        vblank = 1'b0; idle(1);
        vblank = 1'b1; idle(1);
        chk("vblank_int_n", 32'(bus.int_n), 32'h0);
        access(16'h0038, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1);
        chk("ack_di", 32'(bus.di), 32'hCF);
        chk("ack_int_n", 32'(bus.int_n), 32'h1);

        // disabling clears pending and masks later edges
        vblank = 1'b0; idle(1);
        vblank = 1'b1; idle(1);
        chk("pend_again_int_n", 32'(bus.int_n), 32'h0);
        access(16'h5000, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1);
        chk("disable_int_n", 32'(bus.int_n), 32'h1);
        vblank = 1'b0; idle(1);
        vblank = 1'b1; idle(1);
        chk("masked_int_n", 32'(bus.int_n), 32'h1);

        // randomized traffic
        vb_rand = 1'b1;
        for (int i = 0; i < 400; i++) begin
            int          kind;
            int          lat;
            logic [15:0] a;
            logic        wr, nrd, io, m1;
            logic [7:0]  d;
            kind = $urandom_range(0, 9);
            wr = 1'($urandom_range(0, 1)); nrd = 1'b0; io = 1'b0; m1 = 1'b1;
            d = 8'($urandom); lat = $urandom_range(1, 4);
            in0 = 8'($urandom); in1 = 8'($urandom);
            a = 16'($urandom);
            case (kind)
                0, 1, 2: a = 16'($urandom_range(0, 32'h4FFF));
                3: begin
                    case ($urandom_range(0, 2))
                        0: a = 16'h5000;
                        1: a = 16'h5040;
                        default: a = 16'h5000 | 16'($urandom_range(0, 255));
                    endcase
                end
                4: a = 16'($urandom_range(32'h5100, 32'hFFFF));
                5: begin
                    io = 1'b1; wr = 1'b1;
                    if ($urandom_range(0, 1) == 1) a[7:0] = 8'h00;
                end
                6: begin io = 1'b1; wr = 1'b0; end
                7: begin io = 1'b1; m1 = 1'b0; wr = 1'b0; end
                8: begin a = 16'h5000; wr = 1'b1; end
                default: begin wr = 1'b0; nrd = 1'b1; io = 1'($urandom_range(0, 1)); end
            endcase
            access(a, wr, nrd, io, m1, d, lat);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        vb_rand = 1'b0;

        // asynchronous reset in the middle of a memory wait
        access(16'h5000, 1'b1, 1'b1, 1'b0, 1'b1, 8'h01, 1);
        vblank = 1'b0; idle(1);
        vblank = 1'b1; idle(1);
        chk("pre_rst_int_n", 32'(bus.int_n), 32'h0);
        bus.ts = T2; bus.A = 16'h0200; bus.write = 1'b0; bus.no_read = 1'b0;
        bus.iorq = 1'b0; bus.m1_n = 1'b1; bus.mem_ack = 1'b0;
        exp_wait_n = 1'b0;
        tick();
        chk_en = 1'b0;
        chk("pre_rst_mem_req", 32'(bus.mem_req), 32'h1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_mem_req", 32'(bus.mem_req), 32'h0);
        chk("async_rst_wait_n", 32'(bus.wait_n), 32'h1);
        chk("async_rst_int_n", 32'(bus.int_n), 32'h1);
        chk("async_rst_di", 32'(bus.di), 32'hFF);
        m_irq_en = 0; m_pending = 0; m_vblank_prev = 0; m_vector = 8'h00;
        exp_di = 8'hFF; exp_wait_n = 1'b1; exp_int_n = 1'b1; exp_mem_req = 1'b0;
        bus.ts = T1;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk_en = 1'b1;
        bus.mem_ack = 1'b1; bus.mem_rdata = 8'h77;
        tick();
        bus.mem_ack = 1'b0;
        chk("stray_ack_di", 32'(bus.di), 32'hFF);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pacman_bus_responder.md
PACMAN_BUS_RESPONDER -- requirements
Module: pacman_bus_responder

Interface
REQ-001 The block SHALL have one clock and asynchronous active-low reset: clk input 1 (rising-edge clock), reset_n input 1 (async active-low reset).
REQ-002 CPU-side inputs SHALL be: m1_n 1, iorq 1 (active-high), no_read 1, write 1, rfsh_n 1, A 16, dout 8, ts 7 (one-hot T-state, ts[1]=T2).
REQ-003 CPU-side outputs SHALL be: di 8 (read data), wait_n 1, int_n 1.
REQ-004 Memory-side ports SHALL be: mem_req out 1, mem_we out 1, mem_addr out 15, mem_wdata out 8, mem_rdata in 8, mem_ack in 1 (single-cycle pulse).
REQ-005 Board inputs SHALL be: vblank in 1 (level), in0 in 8, in1 in 8.

Function
REQ-006 Access start SHALL be the cycle with ts[1]=1, rfsh_n=1, FSM in IDLE; type is write if write=1, read if write=0 and no_read=0, otherwise none.
REQ-007 Decode: iorq=1 -> IO; 0x0000-0x3FFF ROM; 0x4000-0x4FFF RAM; 0x5000-0x50FF REG; else UNMAPPED.
REQ-008 FSM states SHALL be IDLE, MEM_WAIT, DONE.
REQ-009 ROM/RAM access: IDLE->MEM_WAIT; mem_req=1 held through MEM_WAIT; mem_addr=A[14:0], mem_we=write, mem_wdata=dout, all stable while mem_req=1.
REQ-010 ROM write SHALL NOT assert mem_req; treated as REG-style zero-wait completion.
REQ-011 wait_n SHALL be 0 combinationally in a ROM/RAM start cycle and every MEM_WAIT cycle, 1 otherwise.
REQ-012 On mem_ack in MEM_WAIT: di<=mem_rdata (reads), mem_req drops next cycle, ->DONE.
REQ-013 REG/IO/UNMAPPED/ROM-write access SHALL complete zero-wait: di registered at start edge, ->DONE.
REQ-014 REG reads: 0x5000 -> in0, 0x5040 -> in1, other REG -> 0xFF; UNMAPPED read -> 0xFF.
REQ-015 REG write 0x5000 SHALL set irq_en<=dout[0]; other REG writes ignored.
REQ-016 IO write with A[7:0]=0x00 SHALL latch vector<=dout; other IO writes ignored; IO reads return 0xFF.
REQ-017 DONE SHALL return to IDLE when ts[1]=0 (one access per T2 window).
REQ-018 vblank rising edge with irq_en=1 SHALL set pending; int_n = ~pending.
REQ-019 Acknowledge (m1_n=0 and iorq=1 at access start) SHALL drive di=vector, clear pending, not touch memory.
REQ-020 irq_en<=0 SHALL clear pending same edge; vblank edge coinciding with ack SHALL leave pending=1.
REQ-021 mem_ack outside MEM_WAIT SHALL be ignored.

Reset
REQ-022 Reset SHALL force: FSM=IDLE, di=0xFF, wait_n=1, int_n=1, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, irq_en=0, vector=0x00, pending=0, vblank edge register=0.
REQ-023 Reset asserted in MEM_WAIT SHALL drop mem_req and wait_n=1 immediately (asynchronously); late mem_ack after reset ignored.

Structure
REQ-024 Package pacman_bus_pkg SHALL hold the FSM state enum, region enum, and address-range/register constants (ROM_END, RAM_BASE, RAM_END, REG_BASE, IN0_ADDR, IN1_ADDR, IRQ_EN_ADDR, VEC_PORT).
REQ-025 Interrupt logic (vblank edge, irq_en, pending, vector, ack) SHALL be sub-module pacman_irq_ctrl; decode and FSM in top.

Verification
REQ-026 ROM read A=0x0123, mem_ack 3 cycles after mem_req, mem_rdata=0x3E -> wait_n=0 for 4 cycles, di=0x3E, mem_we=0.
REQ-027 RAM write A=0x4C00 dout=0x5A -> mem_req=1, mem_we=1, mem_addr=0x4C00, mem_wdata=0x5A until ack; ROM write 0x0010 -> no mem_req, wait_n=1.
REQ-028 Read 0x5040 with in1=0x9F -> di=0x9F zero-wait; read 0x6000 -> di=0xFF.
REQ-029 OUT (0x00),0xCF; write 0x5000=0x01; vblank rise -> int_n=0; ack cycle -> di=0xCF, int_n=1 next cycle.
REQ-030 Pending interrupt then write 0x5000=0x00 -> int_n=1; later vblank rise -> int_n stays 1.
REQ-031 reset_n=0 during MEM_WAIT -> mem_req=0, wait_n=1, int_n=1 same cycle; post-reset stray mem_ack -> no di change.
